lut_mult_seq_ctrl: RTL and testbench

- Iterative 32x32 unsigned multiplier controller.
- Time-multiplexes a single lut_multiplier_2b (N=WIDTH) instance over WIDTH/2 cycles instead of instantiating WIDTH/2 copies in parallel.
- Sequences operand capture, digit selection and shifted accumulation, and presents the 2*WIDTH-bit product over a valid/ready handshake.
- Sits between a requesting datapath and the shared 2-bit LUT multiplier.

---
 rtl/lut_mult_seq_ctrl_if.sv | 14 +
 rtl/lut_mult_seq_ctrl.sv | 101 ++++++++++
 tb/tb_lut_mult_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lut_mult_seq_ctrl_if.sv
// lut_mult_seq_ctrl_if: operand/product valid-ready bundle between a requester and the iterative multiplier.
interface lut_mult_seq_ctrl_if #(parameter int WIDTH = 32);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  modport master (output in_valid, a, b, abort, out_ready, input in_ready, out_valid, p, busy);
  modport slave  (input in_valid, a, b, abort, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/lut_mult_seq_ctrl.sv
// lut_mult_seq_ctrl: iterative WIDTHxWIDTH multiplier reusing one 2-bit LUT multiplier, one digit per cycle.
// Define LUT_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module lut_multiplier_2b #(parameter int N = 32) (
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [1:0]   B,
  output logic [N+1:0] pp
);
  logic [N+1:0] w_a1;
  assign w_a1 = {2'b00, A};
  assign pp = reset ? '0 :
              B == 2'd0 ? '0 :
              B == 2'd1 ? w_a1 :
              B == 2'd2 ? (w_a1 << 1) : (w_a1 + (w_a1 << 1));
endmodule

module lut_mult_seq_ctrl #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  lut_mult_seq_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH / 2);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH / 2 - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_a_q;
  logic [WIDTH-1:0]     r_b_q;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH+1:0]     w_pp;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_last;
  logic                 w_lut_rst;
  assign w_lut_rst = ~reset;
  lut_multiplier_2b #(.N(WIDTH)) u_lut (
    .reset (w_lut_rst),
    .A     (r_a_q),
    .B     (r_b_q[1:0]),
    .pp    (w_pp)
  );
  assign w_sum = r_acc + ({{(WIDTH-2){1'b0}}, w_pp} << {r_idx, 1'b0});
`ifdef LUT_MULT_EARLY_TERM_EN
  assign w_last = (r_idx == LAST) || (r_b_q[WIDTH-1:2] == '0);
`else
  assign w_last = r_idx == LAST;
`endif
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.p         = r_p;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_p         <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a_q      <= bus.a;
          r_b_q      <= bus.b;
          r_acc      <= '0;
          r_idx      <= '0;
          r_state    <= RUN;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
        end
        RUN: if (bus.abort) begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end else begin
          r_acc <= w_sum;
          r_b_q <= r_b_q >> 2;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_p         <= w_sum;
          end
        end
        DONE: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_mult_seq_ctrl.sv
// tb_lut_mult_seq_ctrl: directed vector table plus handshake, reset, abort and busy corner sequences.
module tb_lut_mult_seq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  lut_mult_seq_ctrl_if #(.WIDTH(32)) bus ();
  lut_mult_seq_ctrl #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vecs[10];
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic int exp_lat(input logic [31:0] b);
    int n;
    n = 16;
`ifdef LUT_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 1; i < 16; i++) if ((b >> (2 * i)) != 0) n = i + 1;
`endif
    return n + 1;
  endfunction
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 1;
    while (cnt < 60) begin
      @(posedge clk);
      cnt++;
      #1;
      if (bus.out_valid) break;
    end
    check("out_valid_seen", {63'd0, bus.out_valid}, 64'd1);
  endtask
  initial begin
    int lat;
    int extra;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'd7, 32'd9, 64'd63};
    vecs[2] = '{32'h12345678, 32'd3, 64'h369D0368};
    vecs[3] = '{32'd0, 32'hDEADBEEF, 64'd0};
    vecs[4] = '{32'hDEADBEEF, 32'd0, 64'd0};
    vecs[5] = '{32'h10, 32'h10, 64'h100};
    vecs[6] = '{32'h80000000, 32'd2, 64'h100000000};
    vecs[7] = '{32'hFFFFFFFF, 32'd1, 64'hFFFFFFFF};
    vecs[8] = '{32'hFFFF, 32'hFFFF, 64'hFFFE0001};
    vecs[9] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_p", bus.p, 64'd0);
    @(negedge clk) reset = 1'b1;
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy", i), {63'd0, bus.busy}, 64'd1);
      wait_valid(lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
      check($sformatf("vec%0d_p", i), bus.p, vecs[i].p);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_idle", i), {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
    end
    // reset dropped mid-RUN discards the operation
    start_op(32'h12345678, 32'h9ABCDEF0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_state", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd1);
    check("mid_rst_p", bus.p, 64'd0);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus.out_valid) extra++;
    end
    check("mid_rst_no_valid", 64'(extra), 64'd0);
    @(negedge clk) reset = 1'b1;
    start_op(32'd3, 32'd4);
    wait_valid(lat);
    check("post_rst_p", bus.p, 64'd12);
    @(posedge clk);
    // backpressure holds product and valid
    @(negedge clk) bus.out_ready = 1'b0;
    start_op(32'd7, 32'd9);
    wait_valid(lat);
    check("bp_p", bus.p, 64'd63);
    extra = 0;
    repeat (5) begin
      @(posedge clk);
      #1 if (!bus.out_valid || bus.p !== 64'd63) extra++;
    end
    check("bp_hold", 64'(extra), 64'd0);
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd1);
    check("bp_p_held", bus.p, 64'd63);
    // abort during RUN
    start_op(32'd5, 32'hFFFF0000);
    repeat (6) @(posedge clk);
    @(negedge clk) bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", {61'd0, bus.out_valid, bus.busy, bus.in_ready}, 64'd1);
    check("abort_p", bus.p, 64'd63);
    @(negedge clk) bus.abort = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (bus.out_valid) extra++;
    end
    check("abort_no_valid", 64'(extra), 64'd0);
    start_op(32'd3, 32'd4);
    wait_valid(lat);
    check("post_abort_p", bus.p, 64'd12);
    @(posedge clk);
    // in_valid while busy is ignored
    start_op(32'h10, 32'h10);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) bus.in_valid = 1'b0;
    wait_valid(lat);
    check("busy_ign_p", bus.p, 64'h100);
    @(posedge clk);
    extra = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (bus.out_valid || bus.busy) extra++;
    end
    check("busy_ign_no_second", 64'(extra), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
